// File: rtl/lzc_pkg.sv
// Shared types and helpers for the pipelined leading/trailing bit counter.
// No timing of its own; the mode enum, default width and bit-reverse helper live here.
// No flow control here; the handshake is handled by the stages.
package lzc_pkg;

  typedef enum logic [1:0] {
    OP_CLZ = 2'b00,
    OP_CLO = 2'b01,
    OP_CTZ = 2'b10,
    OP_CTO = 2'b11
  } lzc_op_t;

  localparam int LZC_DEFAULT_WIDTH = 32;

  // Widest operand the bit-reverse helper handles.
  // Narrower operands sit in its top bits, so their reversed image lands in the low bits.
  localparam int LZC_MAX_W = 256;

  function automatic logic [LZC_MAX_W-1:0] bitrev(input logic [LZC_MAX_W-1:0] v);
    logic [LZC_MAX_W-1:0] r;
    for (int i = 0; i < LZC_MAX_W; i++) r[i] = v[LZC_MAX_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/lzc_pipe_if.sv
// Operand/result stream bundle for lzc_pipe: operand+mode+tag in, count+all+tag out.
// Purely wires, so it adds no latency.
// Valid/ready in both directions: in_ready goes back to the issuer and out_ready comes from writeback.
interface lzc_pipe_if
  import lzc_pkg::*;
#(
  parameter int DATAWIDTH = LZC_DEFAULT_WIDTH,
  parameter int TAGW      = 5
);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic [1:0]           in_op;
  logic [TAGW-1:0]      in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_cnt;
  logic                 out_all;
  logic [TAGW-1:0]      out_tag;

  // Producer/consumer side: it issues operands and accepts results.
  modport master (
    output in_valid, in_data, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_cnt, out_all, out_tag
  );

  // Counter side.
  modport slave (
    input  in_valid, in_data, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_cnt, out_all, out_tag
  );

endinterface

// File: rtl/lzc_pipe_stage.sv
// One binary-search level of the counter: it halves the window and adds 2^K when the upper half is all zero.
// Latency is one register. At K==0 it resolves the final 2-bit window.
// in_ready = !valid || out_ready. The payload is held while the stage is valid and downstream stalls.
module lzc_stage
  import lzc_pkg::*;
#(
  parameter int K    = 1,
  parameter int CW   = 6,
  parameter int TAGW = 5,
  localparam int IW  = 2 ** (K + 1),
  localparam int OW  = (K == 0) ? 1 : 2 ** K
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_win,
  input  logic [CW-1:0]   in_cnt,
  input  logic            in_all,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_win,
  output logic [CW-1:0]   out_cnt,
  output logic            out_all,
  output logic [TAGW-1:0] out_tag
);

  logic [OW-1:0] win_nxt;
  logic [CW-1:0] cnt_nxt;

  if (K > 0) begin : g_level
    localparam logic [CW-1:0] STEP = CW'(1) << K;

    // An all-zero upper half contributes 2^K leading zeros, and the search moves to the lower half.
    always_comb begin
      win_nxt = in_win[IW-1:OW];
      cnt_nxt = in_cnt;
      if (in_win[IW-1:OW] == '0) begin
        win_nxt = in_win[OW-1:0];
        cnt_nxt = in_cnt + STEP;
      end
    end
  end else begin : g_final
    // Last 2 bits: 00 adds two and 01 adds one. Nothing is left to search afterwards.
    always_comb begin
      win_nxt = '0;
      case (in_win)
        2'b00:   cnt_nxt = in_cnt + CW'(2);
        2'b01:   cnt_nxt = in_cnt + CW'(1);
        default: cnt_nxt = in_cnt;
      endcase
    end
  end

  assign in_ready = !out_valid || out_ready;

  // Stage register. The payload only moves on a real transfer, so a stalled output stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_win   <= '0;
      out_cnt   <= '0;
      out_all   <= 1'b0;
      out_tag   <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_win <= win_nxt;
        out_cnt <= cnt_nxt;
        out_all <= in_all;
        out_tag <= in_tag;
      end
    end
  end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined CLZ/CLO/CTZ/CTO counter. Every mode is reduced to CLZ in front of stage 0.
// Latency is WIDTH registers: a beat accepted at edge N is valid after edge N+WIDTH-1.
// The ready chain is combinational from out_ready back to in_ready. Bubbles collapse, and in_ready falls once all WIDTH stages are full.
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter int DATAWIDTH = LZC_DEFAULT_WIDTH,
  parameter int WIDTH     = $clog2(DATAWIDTH),
  parameter int TAGW      = 5
) (
  input logic     clk,
  input logic     rst,
  lzc_pipe_if.slave bus
);

  localparam int CW = WIDTH + 1;

  // Index j is the input of stage j. Index WIDTH is the pipe output.
  logic            vld   [0:WIDTH];
  logic            rdy   [0:WIDTH];
  logic [CW-1:0]   cnt   [0:WIDTH];
  logic            all_f [0:WIDTH];
  logic [TAGW-1:0] tag   [0:WIDTH];

  lzc_op_t              op;
  logic [DATAWIDTH-1:0] inv_data;
  logic [DATAWIDTH-1:0] pre;
  logic [LZC_MAX_W-1:0] ext;
  logic [LZC_MAX_W-1:0] rev_wide;

  // Fold the four modes into one CLZ. Ones-counting inverts the operand, and trailing counts reverse it.
  always_comb begin
    op       = lzc_op_t'(bus.in_op);
    inv_data = (op == OP_CLO || op == OP_CTO) ? ~bus.in_data : bus.in_data;
    ext      = '0;
    ext[LZC_MAX_W-1 -: DATAWIDTH] = inv_data;
    rev_wide = bitrev(ext);
    pre      = (op == OP_CTZ || op == OP_CTO) ? rev_wide[DATAWIDTH-1:0] : inv_data;
  end

  if (DATAWIDTH < LZC_MAX_W) begin : g_rev_slack
    logic unused_rev_hi;
    assign unused_rev_hi = ^rev_wide[LZC_MAX_W-1:DATAWIDTH];
  end

  assign vld[0]   = bus.in_valid;
  assign cnt[0]   = '0;
  assign all_f[0] = (pre == '0);
  assign tag[0]   = bus.in_tag;
  assign rdy[WIDTH] = bus.out_ready;

  for (genvar j = 0; j < WIDTH; j++) begin : g_stage
    localparam int IW = DATAWIDTH >> j;
    localparam int OW = (j == WIDTH - 1) ? 1 : IW / 2;

    logic [IW-1:0] win_in;
    logic [OW-1:0] win_out;

    if (j == 0) begin : g_src
      assign win_in = pre;
    end else begin : g_chain
      assign win_in = g_stage[j-1].win_out;
    end

    lzc_stage #(.K(WIDTH - 1 - j), .CW(CW), .TAGW(TAGW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[j]),
      .in_ready  (rdy[j]),
      .in_win    (win_in),
      .in_cnt    (cnt[j]),
      .in_all    (all_f[j]),
      .in_tag    (tag[j]),
      .out_valid (vld[j+1]),
      .out_ready (rdy[j+1]),
      .out_win   (win_out),
      .out_cnt   (cnt[j+1]),
      .out_all   (all_f[j+1]),
      .out_tag   (tag[j+1])
    );
  end

  // The last stage keeps a one-bit window slot that carries no information.
  logic unused_last_win;
  assign unused_last_win = g_stage[WIDTH-1].win_out[0];

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[WIDTH];
  assign bus.out_cnt   = DATAWIDTH'(cnt[WIDTH]);
  assign bus.out_all   = all_f[WIDTH];
  assign bus.out_tag   = tag[WIDTH];

endmodule

// File: tb/tb_lzc_pipe.sv
// Bench for lzc_pipe: table-driven single beats, a width sweep, a streaming scoreboard, backpressure and mid-stream reset.
// Latency is measured in rising edges after the accept edge; WIDTH-1 is expected.
// out_ready is driven by the bench to create stalls.
module tb_lzc_pipe;
  import lzc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lzc_pipe_if #(.DATAWIDTH(32), .TAGW(5)) bus32 ();
  lzc_pipe_if #(.DATAWIDTH(8),  .TAGW(5)) bus8 ();
  lzc_pipe_if #(.DATAWIDTH(64), .TAGW(5)) bus64 ();

  lzc_pipe #(.DATAWIDTH(32), .TAGW(5)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  lzc_pipe #(.DATAWIDTH(8),  .TAGW(5)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  lzc_pipe #(.DATAWIDTH(64), .TAGW(5)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: walk from the counted end and stop at the first bit that differs.
  function automatic int ref_count(input logic [63:0] d, input logic [1:0] op, input int dw);
    int  c  = 0;
    bit  go = 1'b1;
    for (int i = 0; i < dw; i++) begin
      int idx = op[1] ? i : dw - 1 - i;
      if (go && d[idx] == op[0]) c++;
      else go = 1'b0;
    end
    return c;
  endfunction

  // ---------------- single-beat helpers (any of the three DUTs) ----------------
  task automatic drive_in(input int w, input bit v, input logic [63:0] d,
                          input logic [1:0] op, input logic [4:0] tg);
    case (w)
      8:  begin bus8.in_valid = v;  bus8.in_data = d[7:0];   bus8.in_op = op;  bus8.in_tag = tg;  end
      64: begin bus64.in_valid = v; bus64.in_data = d;       bus64.in_op = op; bus64.in_tag = tg; end
      default: begin bus32.in_valid = v; bus32.in_data = d[31:0]; bus32.in_op = op; bus32.in_tag = tg; end
    endcase
  endtask

  task automatic read_out(input int w, output bit v, output logic [63:0] c,
                          output bit a, output logic [4:0] tg);
    case (w)
      8:  begin v = bus8.out_valid;  c = 64'(bus8.out_cnt);  a = bus8.out_all;  tg = bus8.out_tag;  end
      64: begin v = bus64.out_valid; c = bus64.out_cnt;      a = bus64.out_all; tg = bus64.out_tag; end
      default: begin v = bus32.out_valid; c = 64'(bus32.out_cnt); a = bus32.out_all; tg = bus32.out_tag; end
    endcase
  endtask

  task automatic send_one(input int w, input logic [63:0] d, input logic [1:0] op,
                          input logic [4:0] tg_in, output int lat, output logic [63:0] c,
                          output bit a, output logic [4:0] tg);
    bit v;
    @(negedge clk);
    drive_in(w, 1'b1, d, op, tg_in);
    @(posedge clk);
    #1;
    drive_in(w, 1'b0, '0, 2'b00, 5'd0);
    lat = 0;
    read_out(w, v, c, a, tg);
    while (!v && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      read_out(w, v, c, a, tg);
    end
  endtask

  // ---------------- streaming helpers (32-bit DUT, scoreboard) ----------------
  typedef struct {
    int         cnt;
    bit         all;
    logic [4:0] tag;
  } exp_t;

  exp_t  sb[$];
  string sb_name = "stream";
  bit    s_in_ready, s_out_valid, s_in_fire, s_out_fire;
  int    out_count = 0;

  task automatic step(input bit v, input logic [31:0] d, input logic [1:0] op,
                      input logic [4:0] tg, input bit ordy);
    exp_t e;
    @(negedge clk);
    bus32.in_valid  = v;
    bus32.in_data   = d;
    bus32.in_op     = op;
    bus32.in_tag    = tg;
    bus32.out_ready = ordy;
    #1;
    s_in_ready  = bus32.in_ready;
    s_out_valid = bus32.out_valid;
    s_in_fire   = v && bus32.in_ready;
    s_out_fire  = bus32.out_valid && ordy;
    if (s_out_fire) begin
      out_count++;
      check({sb_name, "_expected_beat"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({sb_name, "_result"}, {26'd0, bus32.out_cnt, bus32.out_all, bus32.out_tag},
              {26'd0, 32'(e.cnt), e.all, e.tag});
      end
    end
    if (s_in_fire) begin
      e.cnt = ref_count({32'd0, d}, op, 32);
      e.all = (e.cnt == 32);
      e.tag = tg;
      sb.push_back(e);
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [31:0] data;
    lzc_op_t     op;
    int          cnt;
    bit          all;
  } vec_t;

  typedef struct {
    int          w;
    logic [63:0] data;
    lzc_op_t     op;
    int          cnt;
    bit          all;
    int          lat;
  } sweep_t;

  vec_t   vt [15];
  sweep_t sw [6];

  initial begin
    int          lat;
    logic [63:0] c;
    bit          a;
    logic [4:0]  tg;
    int          stalls, gaps, accepted, unstable;
    bit          started, have_hold;
    logic [37:0] hold, cur;

    vt[0]  = '{32'h0001_0000, OP_CLZ, 15, 1'b0};
    vt[1]  = '{32'h0000_0000, OP_CLZ, 32, 1'b1};
    vt[2]  = '{32'h8000_0000, OP_CLZ,  0, 1'b0};
    vt[3]  = '{32'hFFF0_000F, OP_CLO, 12, 1'b0};
    vt[4]  = '{32'hFFF0_000F, OP_CTO,  4, 1'b0};
    vt[5]  = '{32'hFFF0_000F, OP_CTZ,  0, 1'b0};
    vt[6]  = '{32'hFFF0_000F, OP_CLZ,  0, 1'b0};
    vt[7]  = '{32'hFFFF_FFFF, OP_CLO, 32, 1'b1};
    vt[8]  = '{32'h0000_0001, OP_CLZ, 31, 1'b0};
    vt[9]  = '{32'h0000_0100, OP_CTZ,  8, 1'b0};
    vt[10] = '{32'hFFFF_FFFF, OP_CTO, 32, 1'b1};
    vt[11] = '{32'h0000_0000, OP_CTO,  0, 1'b0};
    vt[12] = '{32'hFFFF_FFFE, OP_CLO, 31, 1'b0};
    vt[13] = '{32'h0000_0000, OP_CTZ, 32, 1'b1};
    vt[14] = '{32'h7FFF_FFFF, OP_CLO,  0, 1'b0};

    // Latency column is WIDTH-1 edges after the accept edge: 3 registers at 8 bits, 6 at 64.
    sw[0] = '{8,  64'h01,                  OP_CLZ,  7, 1'b0, 2};
    sw[1] = '{8,  64'h00,                  OP_CLZ,  8, 1'b1, 2};
    sw[2] = '{8,  64'hF0,                  OP_CTZ,  4, 1'b0, 2};
    sw[3] = '{64, 64'h0000_0100_0000_0000, OP_CTZ, 40, 1'b0, 5};
    sw[4] = '{64, 64'hFFFF_FFFF_FFFF_FFFF, OP_CTO, 64, 1'b1, 5};
    sw[5] = '{64, 64'h0000_0000_8000_0000, OP_CLZ, 32, 1'b0, 5};

    drive_in(8, 1'b0, '0, 2'b00, 5'd0);
    drive_in(32, 1'b0, '0, 2'b00, 5'd0);
    drive_in(64, 1'b0, '0, 2'b00, 5'd0);
    bus8.out_ready  = 1'b1;
    bus32.out_ready = 1'b1;
    bus64.out_ready = 1'b1;

    // ---- reset state ----
    #1 rst = 1'b1;
    #3;
    check("reset_out_valid", 64'(bus32.out_valid), 64'd0);
    check("reset_out_cnt",   64'(bus32.out_cnt),   64'd0);
    check("reset_out_all",   64'(bus32.out_all),   64'd0);
    check("reset_out_tag",   64'(bus32.out_tag),   64'd0);
    check("reset_in_ready",  64'(bus32.in_ready),  64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 64'(bus32.in_ready), 64'd1);

    // ---- table-driven single beats, 32-bit ----
    for (int i = 0; i < 15; i++) begin
      send_one(32, {32'd0, vt[i].data}, vt[i].op, 5'(i), lat, c, a, tg);
      check($sformatf("vec%0d_cnt", i), c, 64'(vt[i].cnt));
      check($sformatf("vec%0d_all", i), 64'(a), 64'(vt[i].all));
      check($sformatf("vec%0d_tag", i), 64'(tg), 64'(i));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
    end

    // ---- width sweep ----
    for (int i = 0; i < 6; i++) begin
      send_one(sw[i].w, sw[i].data, sw[i].op, 5'(i + 3), lat, c, a, tg);
      check($sformatf("sweep%0d_w%0d_cnt", i, sw[i].w), c, 64'(sw[i].cnt));
      check($sformatf("sweep%0d_w%0d_all", i, sw[i].w), 64'(a), 64'(sw[i].all));
      check($sformatf("sweep%0d_w%0d_tag", i, sw[i].w), 64'(tg), 64'(i + 3));
      check($sformatf("sweep%0d_w%0d_latency", i, sw[i].w), 64'(lat), 64'(sw[i].lat));
    end

    // ---- back-to-back stream, out_ready held high ----
    sb_name   = "stream";
    out_count = 0;
    stalls    = 0;
    gaps      = 0;
    started   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, $urandom >> $urandom_range(0, 31), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), 1'b1);
      if (!s_in_ready) stalls++;
      if (started && !s_out_valid) gaps++;
      if (s_out_valid) started = 1'b1;
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      step(1'b0, '0, 2'b00, 5'd0, 1'b1);
      if (!s_out_valid) gaps++;
    end
    check("stream_in_stalls", 64'(stalls), 64'd0);
    check("stream_output_gaps", 64'(gaps), 64'd0);
    check("stream_result_count", 64'(out_count), 64'd100);
    check("stream_left_in_flight", 64'(sb.size()), 64'd0);

    // ---- backpressure: out_ready low for 10 cycles ----
    sb_name   = "backpressure";
    out_count = 0;
    accepted  = 0;
    unstable  = 0;
    have_hold = 1'b0;
    hold      = '0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h0000_8000 >> i, 2'b00, 5'(i + 10), 1'b0);
      if (s_in_fire) accepted++;
      if (s_out_valid) begin
        cur = {bus32.out_cnt, bus32.out_all, bus32.out_tag};
        if (!have_hold) begin
          hold      = cur;
          have_hold = 1'b1;
        end else if (cur !== hold) begin
          unstable++;
        end
      end
    end
    check("bp_beats_accepted", 64'(accepted), 64'd5);
    check("bp_in_ready_when_full", 64'(s_in_ready), 64'd0);
    check("bp_output_presented", 64'(have_hold), 64'd1);
    check("bp_output_unstable_cycles", 64'(unstable), 64'd0);
    // With a full pipe, releasing out_ready lets a new beat in during the same cycle.
    step(1'b1, 32'h0000_0003, 2'b00, 5'd20, 1'b1);
    check("bp_accept_while_draining", 64'(s_in_ready), 64'd1);
    for (int i = 0; i < 30 && sb.size() != 0; i++) step(1'b0, '0, 2'b00, 5'd0, 1'b1);
    check("bp_drained_count", 64'(out_count), 64'd6);
    check("bp_left_in_flight", 64'(sb.size()), 64'd0);

    // ---- reset with beats in flight ----
    sb_name = "reset";
    step(1'b1, 32'h0000_00FF, 2'b00, 5'd7, 1'b0);
    step(1'b1, 32'h0000_0F00, 2'b00, 5'd8, 1'b0);
    step(1'b1, 32'h0000_1000, 2'b00, 5'd9, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 2'b00, 5'd0, 1'b0);
    check("rst_prefill_out_valid", 64'(s_out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_async_out_cnt",   64'(bus32.out_cnt),   64'd0);
    check("rst_async_out_tag",   64'(bus32.out_tag),   64'd0);
    check("rst_async_in_ready",  64'(bus32.in_ready),  64'd1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready_after_release", 64'(bus32.in_ready), 64'd1);
    out_count = 0;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 2'b00, 5'd0, 1'b1);
    check("rst_no_stale_results", 64'(out_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
